// File: rtl/inst_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : inst_cache_pkg
// Purpose  : Shared CPU definitions used by the instruction cache: bus
//            widths, valid encodings, cache state encodings and the default
//            index width.
// Revision : 1.0 - initial release
// ============================================================================
package inst_cache_pkg;

   localparam int AddressBus        = 32;
   localparam int InstBus           = 32;
   localparam int ICACHE_INDEX_BITS = 8;

   localparam logic Valid   = 1'b1;
   localparam logic Invalid = 1'b0;

   typedef enum logic [0:0] {
      IcIdle = 1'b0,
      IcMiss = 1'b1
   } icache_state_e;

endpackage
`default_nettype wire

// File: rtl/inst_cache_if.sv
`default_nettype none
// ============================================================================
// Module   : inst_cache_if
// Purpose  : Fetch-side and memory-controller-side signals of the
//            instruction cache. The slave modport is the cache's view; the
//            master modport is the surrounding IF unit / memory controller.
// Revision : 1.0 - initial release
// ============================================================================
interface inst_cache_if
   import inst_cache_pkg::*;
#(
   parameter int ADDR_W = AddressBus,
   parameter int INST_W = InstBus
) ();

   logic              IF_valid;
   logic [ADDR_W-1:0] IF_addr;
   logic              IF_inst_valid;
   logic [INST_W-1:0] IF_inst;
   logic              MemCtrl_inst_read_valid;
   logic [ADDR_W-1:0] MemCtrl_inst_addr;
   logic              MemCtrl_inst_valid;
   logic [INST_W-1:0] MemCtrl_inst;

   modport slave (
      input  IF_valid, IF_addr, MemCtrl_inst_valid, MemCtrl_inst,
      output IF_inst_valid, IF_inst, MemCtrl_inst_read_valid, MemCtrl_inst_addr
   );

   modport master (
      output IF_valid, IF_addr, MemCtrl_inst_valid, MemCtrl_inst,
      input  IF_inst_valid, IF_inst, MemCtrl_inst_read_valid, MemCtrl_inst_addr
   );

endinterface
`default_nettype wire

// File: rtl/inst_cache_array.sv
`default_nettype none
// ============================================================================
// Module   : icache_array
// Purpose  : Direct-mapped line storage (valid, tag, data). Synchronous
//            write, asynchronous read; valid bits clear on reset while tag
//            and data contents are left untouched.
// Revision : 1.0 - initial release
// ============================================================================
module icache_array
   import inst_cache_pkg::*;
#(
   parameter int INDEX_BITS = ICACHE_INDEX_BITS,
   parameter int TAG_W      = 22,
   parameter int DATA_W     = InstBus
) (
   input  wire logic                  clk,
   input  wire logic                  rst,
   input  wire logic [INDEX_BITS-1:0] rd_index,
   output logic                       rd_valid,
   output logic      [TAG_W-1:0]      rd_tag,
   output logic      [DATA_W-1:0]     rd_data,
   input  wire logic                  we,
   input  wire logic [INDEX_BITS-1:0] wr_index,
   input  wire logic [TAG_W-1:0]      wr_tag,
   input  wire logic [DATA_W-1:0]     wr_data
);

   localparam int LINES = 1 << INDEX_BITS;

   logic [LINES-1:0]  r_valid;
   logic [TAG_W-1:0]  r_tag  [LINES];
   logic [DATA_W-1:0] r_data [LINES];

   // Valid bits: cleared by reset, set by a refill write.
   always_ff @(posedge clk) begin
      if (rst)
         r_valid <= '0;
      else if (we)
         r_valid[wr_index] <= Valid;
   end

   // Tag/data payload: written on refill only, never reset.
   always_ff @(posedge clk) begin
      if (we && !rst) begin
         r_tag[wr_index]  <= wr_tag;
         r_data[wr_index] <= wr_data;
      end
   end

   assign rd_valid = r_valid[rd_index];
   assign rd_tag   = r_tag[rd_index];
   assign rd_data  = r_data[rd_index];

endmodule
`default_nettype wire

// File: rtl/inst_cache.sv
`default_nettype none
// ============================================================================
// Module   : inst_cache
// Purpose  : Direct-mapped, one-word-per-line instruction cache between the
//            fetch unit and the memory controller. Hits answer one cycle
//            after the request; misses issue a single word fetch and forward
//            the returned word while writing it into the line.
// Revision : 1.0 - initial release
// ============================================================================
module inst_cache
   import inst_cache_pkg::*;
#(
   parameter int INDEX_BITS = ICACHE_INDEX_BITS,
   parameter int ADDR_W     = AddressBus,
   parameter int INST_W     = InstBus
) (
   input  wire logic    clk,
   input  wire logic    rst,
   input  wire logic    rdy,
   input  wire logic    clear,
   inst_cache_if.slave  bus
);

   localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

   icache_state_e     r_state;
   icache_state_e     w_state_nxt;
   logic              r_inst_valid;
   logic              w_inst_valid_nxt;
   logic [INST_W-1:0] r_inst;
   logic [INST_W-1:0] w_inst_nxt;
   logic [ADDR_W-1:0] r_miss_addr;
   logic [ADDR_W-1:0] w_miss_addr_nxt;
   logic              w_we;

   logic              w_rd_valid;
   logic [TAG_W-1:0]  w_rd_tag;
   logic [INST_W-1:0] w_rd_data;
   logic              w_hit;
   logic              w_unused_offset;

   // Byte offset of a word-aligned PC carries no information.
   assign w_unused_offset = ^bus.IF_addr[1:0];

   icache_array #(
      .INDEX_BITS (INDEX_BITS),
      .TAG_W      (TAG_W),
      .DATA_W     (INST_W)
   ) u_array (
      .clk      (clk),
      .rst      (rst),
      .rd_index (bus.IF_addr[INDEX_BITS+1:2]),
      .rd_valid (w_rd_valid),
      .rd_tag   (w_rd_tag),
      .rd_data  (w_rd_data),
      .we       (w_we),
      .wr_index (r_miss_addr[INDEX_BITS+1:2]),
      .wr_tag   (r_miss_addr[ADDR_W-1:INDEX_BITS+2]),
      .wr_data  (bus.MemCtrl_inst)
   );

   assign w_hit = w_rd_valid && (w_rd_tag == bus.IF_addr[ADDR_W-1:INDEX_BITS+2]);

   // State and registered outputs; reset wins over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IcIdle;
         r_inst_valid <= 1'b0;
         r_inst       <= '0;
         r_miss_addr  <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_inst_valid <= w_inst_valid_nxt;
         r_inst       <= w_inst_nxt;
         r_miss_addr  <= w_miss_addr_nxt;
      end
   end

   // Next state and outputs: clear beats stall, stall freezes everything.
   always_comb begin
      w_state_nxt      = r_state;
      w_inst_valid_nxt = 1'b0;
      w_inst_nxt       = r_inst;
      w_miss_addr_nxt  = r_miss_addr;
      w_we             = 1'b0;
      if (clear) begin
         w_state_nxt = IcIdle;
      end else if (rdy) begin
         case (r_state)
            IcIdle: begin
               if (bus.IF_valid) begin
                  if (w_hit) begin
                     w_inst_valid_nxt = 1'b1;
                     w_inst_nxt       = w_rd_data;
                  end else begin
                     w_miss_addr_nxt = bus.IF_addr;
                     w_state_nxt     = IcMiss;
                  end
               end
            end
            IcMiss: begin
               if (bus.MemCtrl_inst_valid) begin
                  w_we             = 1'b1;
                  w_inst_valid_nxt = 1'b1;
                  w_inst_nxt       = bus.MemCtrl_inst;
                  w_state_nxt      = IcIdle;
               end
            end
            default: w_state_nxt = IcIdle;
         endcase
      end
   end

   // Request drops the same cycle the word arrives so no duplicate fetch starts.
   assign bus.MemCtrl_inst_read_valid = (r_state == IcMiss) && !bus.MemCtrl_inst_valid;
   assign bus.MemCtrl_inst_addr       = r_miss_addr;
   assign bus.IF_inst_valid           = r_inst_valid;
   assign bus.IF_inst                 = r_inst;

endmodule
`default_nettype wire

// File: tb/tb_inst_cache.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_cache
// Purpose  : Self-checking bench for inst_cache. Expected responses are
//            queued when a hit or refill is stimulated and popped when the
//            cache raises IF_inst_valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_cache;

   logic clk;
   logic rst;
   logic rdy;
   logic clear;

   int n_checks;
   int n_errors;
   logic [31:0] sb[$];

   inst_cache_if bus ();

   inst_cache dut (
      .clk   (clk),
      .rst   (rst),
      .rdy   (rdy),
      .clear (clear),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: count it and report a mismatch.
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Scoreboard monitor: every response pulse must match the oldest queued word.
   always @(negedge clk) begin
      if (bus.IF_inst_valid === 1'b1) begin
         logic [31:0] w_exp;
         w_exp = (sb.size() != 0) ? sb.pop_front() : ~bus.IF_inst;
         check("resp_data", bus.IF_inst, w_exp);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [31:0] a);
      bus.IF_valid = 1'b1;
      bus.IF_addr  = a;
      tick();
      bus.IF_valid = 1'b0;
   endtask

   task automatic hit(input logic [31:0] a, input logic [31:0] d);
      sb.push_back(d);
      fetch(a);
      check("hit_iv", bus.IF_inst_valid, 1);
      check("hit_inst", bus.IF_inst, d);
      check("hit_rv", bus.MemCtrl_inst_read_valid, 0);
   endtask

   task automatic miss(input logic [31:0] a);
      fetch(a);
      check("miss_rv", bus.MemCtrl_inst_read_valid, 1);
      check("miss_addr", bus.MemCtrl_inst_addr, a);
      check("miss_iv", bus.IF_inst_valid, 0);
   endtask

   task automatic refill(input logic [31:0] d, input int wait_cycles);
      logic [31:0] w_addr;
      w_addr = bus.MemCtrl_inst_addr;
      repeat (wait_cycles) begin
         tick();
         check("wait_rv", bus.MemCtrl_inst_read_valid, 1);
         check("wait_addr", bus.MemCtrl_inst_addr, w_addr);
      end
      bus.MemCtrl_inst_valid = 1'b1;
      bus.MemCtrl_inst       = d;
      #1;
      check("rv_drop", bus.MemCtrl_inst_read_valid, 0);
      sb.push_back(d);
      tick();
      bus.MemCtrl_inst_valid = 1'b0;
      check("refill_iv", bus.IF_inst_valid, 1);
      check("refill_inst", bus.IF_inst, d);
      check("refill_rv", bus.MemCtrl_inst_read_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      rdy = 1'b1;
      clear = 1'b0;
      bus.IF_valid = 1'b0;
      bus.IF_addr = '0;
      bus.MemCtrl_inst_valid = 1'b0;
      bus.MemCtrl_inst = '0;
      tick();
      tick();
      rst = 1'b0;
      check("rst_iv", bus.IF_inst_valid, 0);
      check("rst_inst", bus.IF_inst, 0);
      check("rst_addr", bus.MemCtrl_inst_addr, 0);
      check("rst_rv", bus.MemCtrl_inst_read_valid, 0);

      // Cold miss, word returns five cycles after the request is seen.
      miss(32'h0000_1000);
      refill(32'h0050_0093, 4);

      // Hit, then back-to-back hits.
      hit(32'h0000_1000, 32'h0050_0093);
      hit(32'h0000_1000, 32'h0050_0093);
      hit(32'h0000_1000, 32'h0050_0093);

      // Conflict on index 0; the second miss is aborted by a flush.
      miss(32'h0000_1400);
      refill(32'hDEAD_BEEF, 2);
      miss(32'h0000_1000);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("abort_rv", bus.MemCtrl_inst_read_valid, 0);

      // Flush two cycles into a miss; a request alongside clear is dropped.
      miss(32'h0000_2000);
      tick();
      check("pre_clr_rv", bus.MemCtrl_inst_read_valid, 1);
      clear = 1'b1;
      bus.IF_valid = 1'b1;
      bus.IF_addr = 32'h0000_1400;
      tick();
      clear = 1'b0;
      bus.IF_valid = 1'b0;
      check("clr_rv", bus.MemCtrl_inst_read_valid, 0);
      check("clr_iv", bus.IF_inst_valid, 0);

      // A stray word in IDLE must neither respond nor write the array.
      bus.MemCtrl_inst_valid = 1'b1;
      bus.MemCtrl_inst = 32'h1111_1111;
      tick();
      bus.MemCtrl_inst_valid = 1'b0;
      check("stray_iv", bus.IF_inst_valid, 0);
      hit(32'h0000_1400, 32'hDEAD_BEEF);

      // Stall during a miss holds request and address; IF_valid is ignored.
      miss(32'h0000_3004);
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.IF_valid = 1'b1;
         bus.IF_addr = 32'h0000_1400;
         tick();
         check("stall_rv", bus.MemCtrl_inst_read_valid, 1);
         check("stall_addr", bus.MemCtrl_inst_addr, 32'h0000_3004);
         check("stall_iv", bus.IF_inst_valid, 0);
      end
      bus.IF_valid = 1'b0;
      rdy = 1'b1;
      refill(32'hCAFE_F00D, 1);
      tick();
      check("single_pulse", bus.IF_inst_valid, 0);
      hit(32'h0000_3004, 32'hCAFE_F00D);

      // Reset during a miss clears outputs and invalidates cached lines.
      miss(32'h0000_4008);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mrst_iv", bus.IF_inst_valid, 0);
      check("mrst_inst", bus.IF_inst, 0);
      check("mrst_addr", bus.MemCtrl_inst_addr, 0);
      check("mrst_rv", bus.MemCtrl_inst_read_valid, 0);
      miss(32'h0000_1400);
      refill(32'hDEAD_BEEF, 0);
      hit(32'h0000_1400, 32'hDEAD_BEEF);

      repeat (3) tick();
      check("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
